// File: rtl/plic_mt.sv
// plic_mt: multi-target platform-level interrupt controller.
// Sources pass a 2-flop synchroniser, a gateway (level, or edge when
// PLIC_MT_EDGE_TRIG_EN is defined) and a per-target priority selector.
// Without PLIC_MT_EDGE_TRIG_EN every source is level-triggered and the
// trigger registers, edge detectors and edge latches do not exist.

module plic_mt_target #(
    parameter int NUM_SOURCES = 32,
    parameter int PRIO_BITS   = 3
) (
    input  logic [NUM_SOURCES-1:0]                pending,
    input  logic [NUM_SOURCES-1:0]                enable,
    input  logic [NUM_SOURCES-1:0][PRIO_BITS-1:0] prio,
    input  logic [PRIO_BITS-1:0]                  thr,
    output logic [5:0]                            sel_id,
    output logic                                  any
);
    logic [PRIO_BITS-1:0] best;

    // Upward scan that only replaces on a strictly higher priority, so ties keep the lowest ID.
    always_comb begin
        sel_id = '0;
        any    = 1'b0;
        best   = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (pending[i] && enable[i] && prio[i] != '0 && prio[i] > thr &&
                (!any || prio[i] > best)) begin
                any    = 1'b1;
                best   = prio[i];
                sel_id = 6'(i);
            end
        end
    end
endmodule

module plic_mt #(
    parameter int NUM_SOURCES = 32,
    parameter int NUM_TARGETS = 2,
    parameter int PRIO_BITS   = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   stb_i,
    input  logic [11:0]            adr_i,
    input  logic [3:0]             byte_sel_i,
    input  logic                   we_i,
    input  logic [31:0]            dat_i,
    output logic [31:0]            dat_o,
    input  logic [NUM_SOURCES-1:0] irq_sources_i,
    output logic [NUM_TARGETS-1:0] irq_o
);
    // Source 0 is reserved: every per-source vector is masked with this.
    localparam logic [NUM_SOURCES-1:0] SRC_MASK = {{(NUM_SOURCES-1){1'b1}}, 1'b0};

    logic [NUM_SOURCES-1:0][PRIO_BITS-1:0] prio;
    logic [NUM_TARGETS-1:0][NUM_SOURCES-1:0] en;
    logic [NUM_TARGETS-1:0][PRIO_BITS-1:0] thr;
    logic [NUM_SOURCES-1:0] sync1, sync2, pending, inflight, pend_nxt, infl_nxt, clm, cpl;
    logic [NUM_TARGETS-1:0][5:0] sel_id;
    logic [NUM_TARGETS-1:0] any;
    logic aligned, wr, hit_prio, hit_pend, hit_en, hit_thr, hit_clm, wsel;
    logic [5:0] pidx;
    logic [1:0] tsel;

    function automatic logic [31:0] bmerge(input logic [31:0] cur, input logic [31:0] nw,
                                           input logic [3:0] be);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Byte-masked write of one 32-bit half of a per-source bit vector.
    function automatic logic [NUM_SOURCES-1:0] wr_word(input logic [NUM_SOURCES-1:0] cur,
                                                       input logic w, input logic [31:0] d,
                                                       input logic [3:0] be);
        logic [63:0] full;
        full = 64'(cur);
        if (w) full[63:32] = bmerge(full[63:32], d, be);
        else   full[31:0]  = bmerge(full[31:0], d, be);
        return full[NUM_SOURCES-1:0] & SRC_MASK;
    endfunction

    function automatic logic [31:0] rd_word(input logic [NUM_SOURCES-1:0] cur, input logic w);
        logic [63:0] full;
        full = 64'(cur);
        return w ? full[63:32] : full[31:0];
    endfunction

    // Word decode; byte addresses that are not word aligned are treated as unmapped.
    assign aligned  = adr_i[1:0] == 2'b00;
    assign wr       = stb_i && we_i;
    assign pidx     = adr_i[7:2];
    assign tsel     = adr_i[5:4];
    assign wsel     = adr_i[2];
    assign hit_prio = aligned && adr_i[11:8] == 4'h0;
    assign hit_pend = aligned && adr_i[11:3] == 9'h020;
    assign hit_en   = aligned && adr_i[11:6] == 6'h08 && !adr_i[3];
    assign hit_thr  = aligned && adr_i[11:6] == 6'h10 && adr_i[3:2] == 2'b00;
    assign hit_clm  = aligned && adr_i[11:6] == 6'h10 && adr_i[3:2] == 2'b01;

`ifdef PLIC_MT_EDGE_TRIG_EN
    logic [NUM_SOURCES-1:0] trig, trig_nxt, sync3, rise, edge_lat, lat_nxt;
    logic hit_trig;
    assign hit_trig = aligned && adr_i[11:3] == 9'h030;
    assign trig_nxt = (wr && hit_trig) ? wr_word(trig, wsel, dat_i, byte_sel_i) : trig;
    assign rise     = sync2 & ~sync3;
`endif

    // Priority, enable and threshold registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio <= '0;
            en   <= '0;
            thr  <= '0;
        end else if (wr) begin
            for (int i = 1; i < NUM_SOURCES; i++)
                if (hit_prio && byte_sel_i[0] && pidx == 6'(i)) prio[i] <= dat_i[PRIO_BITS-1:0];
            for (int t = 0; t < NUM_TARGETS; t++) begin
                if (hit_en && tsel == 2'(t)) en[t] <= wr_word(en[t], wsel, dat_i, byte_sel_i);
                if (hit_thr && byte_sel_i[0] && tsel == 2'(t)) thr[t] <= dat_i[PRIO_BITS-1:0];
            end
        end
    end

    // Source synchroniser; the third stage only exists to detect rising edges.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1 <= '0;
            sync2 <= '0;
`ifdef PLIC_MT_EDGE_TRIG_EN
            sync3 <= '0;
`endif
        end else begin
            sync1 <= irq_sources_i & SRC_MASK;
            sync2 <= sync1;
`ifdef PLIC_MT_EDGE_TRIG_EN
            sync3 <= sync2;
`endif
        end
    end

    // Claim reads and complete writes, decoded to one-hot per source.
    always_comb begin
        clm = '0;
        cpl = '0;
        for (int t = 0; t < NUM_TARGETS; t++) begin
            if (stb_i && hit_clm && tsel == 2'(t)) begin
                for (int i = 1; i < NUM_SOURCES; i++) begin
                    if (!we_i && sel_id[t] == 6'(i)) clm[i] = 1'b1;
                    if (we_i && dat_i == 32'(i) && inflight[i] && en[t][i]) cpl[i] = 1'b1;
                end
            end
        end
    end

    // Gateways: claim is applied last so it wins over any same-edge pending set.
    always_comb begin
        pend_nxt = pending;
        infl_nxt = inflight;
`ifdef PLIC_MT_EDGE_TRIG_EN
        lat_nxt  = edge_lat;
`endif
        for (int i = 0; i < NUM_SOURCES; i++) begin
`ifdef PLIC_MT_EDGE_TRIG_EN
            if (trig[i]) begin
                if (rise[i] && (!inflight[i] || cpl[i])) pend_nxt[i] = 1'b1;
                else if (rise[i])                        lat_nxt[i]  = 1'b1;
                if (edge_lat[i] && !inflight[i]) begin
                    pend_nxt[i] = 1'b1;
                    lat_nxt[i]  = 1'b0;
                end
            end else
`endif
            if (sync2[i] && !inflight[i] && !pending[i]) pend_nxt[i] = 1'b1;
            if (cpl[i]) infl_nxt[i] = 1'b0;
            if (clm[i]) begin
                pend_nxt[i] = 1'b0;
                infl_nxt[i] = 1'b1;
            end
`ifdef PLIC_MT_EDGE_TRIG_EN
            if (trig_nxt[i] != trig[i]) lat_nxt[i] = 1'b0;
`endif
        end
        pend_nxt = pend_nxt & SRC_MASK;
        infl_nxt = infl_nxt & SRC_MASK;
`ifdef PLIC_MT_EDGE_TRIG_EN
        lat_nxt  = lat_nxt & SRC_MASK;
`endif
    end

    // Gateway state and registered per-target request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending  <= '0;
            inflight <= '0;
            irq_o    <= '0;
`ifdef PLIC_MT_EDGE_TRIG_EN
            trig     <= '0;
            edge_lat <= '0;
`endif
        end else begin
            pending  <= pend_nxt;
            inflight <= infl_nxt;
            irq_o    <= any;
`ifdef PLIC_MT_EDGE_TRIG_EN
            trig     <= trig_nxt;
            edge_lat <= lat_nxt;
`endif
        end
    end

    for (genvar t = 0; t < NUM_TARGETS; t++) begin : g_tgt
        plic_mt_target #(.NUM_SOURCES(NUM_SOURCES), .PRIO_BITS(PRIO_BITS)) u_tgt (
            .pending (pending),
            .enable  (en[t]),
            .prio    (prio),
            .thr     (thr[t]),
            .sel_id  (sel_id[t]),
            .any     (any[t])
        );
    end

    // Combinational read mux; anything not decoded returns 0.
    always_comb begin
        dat_o = '0;
        if (hit_prio)
            for (int i = 0; i < NUM_SOURCES; i++)
                if (pidx == 6'(i)) dat_o = 32'(prio[i]);
        if (hit_pend) dat_o = rd_word(pending, wsel);
`ifdef PLIC_MT_EDGE_TRIG_EN
        if (hit_trig) dat_o = rd_word(trig, wsel);
`endif
        for (int t = 0; t < NUM_TARGETS; t++) begin
            if (tsel == 2'(t)) begin
                if (hit_en)  dat_o = rd_word(en[t], wsel);
                if (hit_thr) dat_o = 32'(thr[t]);
                if (hit_clm) dat_o = 32'(sel_id[t]);
            end
        end
    end
endmodule

// File: tb/tb_plic_mt.sv
// tb_plic_mt: directed scenarios plus randomized level-source rounds checked
// against a behavioural PLIC model kept in this bench.
module tb_plic_mt;
    localparam int NS = 32, NT = 2, PB = 3, PMAX = (1 << PB) - 1;

    logic          clk_i = 1'b0, rst_ni = 1'b0, stb_i = 1'b0, we_i = 1'b0;
    logic [11:0]   adr_i = '0;
    logic [3:0]    byte_sel_i = '0;
    logic [31:0]   dat_i = '0, dat_o;
    logic [NS-1:0] irq_sources_i = '0;
    logic [NT-1:0] irq_o;
    int n_tests = 0, n_fail = 0;

    plic_mt #(.NUM_SOURCES(NS), .NUM_TARGETS(NT), .PRIO_BITS(PB)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .stb_i(stb_i), .adr_i(adr_i), .byte_sel_i(byte_sel_i),
        .we_i(we_i), .dat_i(dat_i), .dat_o(dat_o), .irq_sources_i(irq_sources_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state
    logic [PB-1:0] m_prio [NS];
    logic [NS-1:0] m_en [NT];
    logic [PB-1:0] m_thr [NT];
    logic [NS-1:0] m_pend, m_infl;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NS; i++) m_prio[i] = '0;
        for (int t = 0; t < NT; t++) begin m_en[t] = '0; m_thr[t] = '0; end
        m_pend = '0;
        m_infl = '0;
    endtask

    // Highest priority above threshold wins; within a priority the lowest ID wins.
    function automatic int m_sel(input int t);
        int r = 0;
        for (int p = PMAX; p > int'(m_thr[t]); p--)
            for (int i = 1; i < NS; i++)
                if (r == 0 && m_pend[i] && m_en[t][i] && int'(m_prio[i]) == p) r = i;
        return r;
    endfunction

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk_i);
        stb_i = 1'b1; we_i = 1'b1; adr_i = a; dat_i = d; byte_sel_i = be;
        @(posedge clk_i); #1;
        stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        @(negedge clk_i);
        stb_i = 1'b1; we_i = 1'b0; adr_i = a;
        #1 d = dat_o;
        @(posedge clk_i); #1;
        stb_i = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        #2 chk("rst_irq_async", 64'(irq_o), 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        m_reset();
    endtask

    task automatic set_prio(input int i, input int p);
        wr(12'(4 * i), 32'(p), 4'hf);
        if (i > 0 && i < NS) m_prio[i] = p[PB-1:0];
    endtask

    task automatic set_en(input int t, input logic [31:0] v);
        wr(12'h200 + 12'(16 * t), v, 4'hf);
        m_en[t] = v & ~32'h1;
    endtask

    task automatic set_thr(input int t, input int v);
        wr(12'h400 + 12'(16 * t), 32'(v), 4'hf);
        m_thr[t] = v[PB-1:0];
    endtask

    task automatic claim(input int t, output logic [31:0] d);
        rd(12'h404 + 12'(16 * t), d);
    endtask

    task automatic cpl(input int t, input logic [31:0] k);
        wr(12'h404 + 12'(16 * t), k, 4'hf);
    endtask

    task automatic pulse(input int i);
        irq_sources_i[i] = 1'b1;
        settle(3);
        irq_sources_i[i] = 1'b0;
        settle(3);
    endtask

    int who [NS];

    initial begin
        logic [31:0] d;
        logic [NS-1:0] src;
        int id;

        // Reset state and register map boundaries
        do_reset();
        chk("rst_irq_o", 64'(irq_o), 0);
        rd(12'h008, d); chk("rst_prio2", d, 0);
        rd(12'h100, d); chk("rst_pend", d, 0);
        rd(12'h200, d); chk("rst_en0", d, 0);
        rd(12'h404, d); chk("rst_claim0", d, 0);
        wr(12'h000, 32'h7, 4'hf);  rd(12'h000, d); chk("prio0_hardwired", d, 0);
        wr(12'h00C, 32'hFD, 4'hf); rd(12'h00C, d); chk("prio3_mask", d, 5);
        wr(12'h00C, 32'h2, 4'he);  rd(12'h00C, d); chk("prio_be0_off", d, 5);
        wr(12'h200, 32'hFFFF_FFFF, 4'hf); rd(12'h200, d); chk("en0_bit0", d, 32'hFFFF_FFFE);
        wr(12'h200, 32'h0, 4'h2);  rd(12'h200, d); chk("en0_bytesel", d, 32'hFFFF_00FE);
        wr(12'h204, 32'hFFFF_FFFF, 4'hf); rd(12'h204, d); chk("en0_hi_absent", d, 0);
        wr(12'h220, 32'hFFFF_FFFF, 4'hf); rd(12'h220, d); chk("en_t2_absent", d, 0);
        rd(12'h800, d); chk("unmapped", d, 0);
        wr(12'h410, 32'h6, 4'hf);  rd(12'h410, d); chk("thr1", d, 6);
        wr(12'h410, 32'h1, 4'he);  rd(12'h410, d); chk("thr1_be0_off", d, 6);
        wr(12'h180, 32'hFFFF_FFFF, 4'hf); rd(12'h180, d);
`ifdef PLIC_MT_EDGE_TRIG_EN
        chk("trig_rw", d, 32'hFFFF_FFFE);
`else
        chk("trig_absent", d, 0);
`endif

        // Latency: irq rises on the 4th edge after the source asserts
        do_reset();
        set_en(0, 32'h4); set_prio(2, 5); set_thr(0, 0);
        @(posedge clk_i); #1 irq_sources_i[2] = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 chk("irq_lat_e3", 64'(irq_o[0]), 0);
        @(posedge clk_i);
        #1 chk("irq_lat_e4", 64'(irq_o[0]), 1);
        claim(0, d); chk("claim_src2", d, 2);
        rd(12'h100, d); chk("pend2_clr", 64'(d[2]), 0);

        // Equal priority: lowest ID first
        do_reset(); irq_sources_i = '0;
        set_prio(3, 4); set_prio(5, 4); set_en(1, 32'h28);
        irq_sources_i[3] = 1'b1; irq_sources_i[5] = 1'b1;
        settle(6);
        claim(1, d); chk("tie_first", d, 3);
        irq_sources_i[3] = 1'b0; settle(4);
        cpl(1, 3);
        claim(1, d); chk("tie_second", d, 5);

        // Strict threshold comparison
        do_reset(); irq_sources_i = '0;
        set_prio(7, 3); set_en(1, 32'h80); set_thr(1, 3);
        irq_sources_i[7] = 1'b1; settle(6);
        chk("thr_equal_blocks", 64'(irq_o[1]), 0);
        set_thr(1, 2);
        chk("thr_write_edge", 64'(irq_o[1]), 0);
        @(posedge clk_i);
        #1 chk("thr_next_edge", 64'(irq_o[1]), 1);

        // Level re-pend; completes from a non-enabled target or with an out-of-range ID are ignored
        do_reset(); irq_sources_i = '0;
        set_prio(4, 1); set_en(0, 32'h10);
        irq_sources_i[4] = 1'b1; settle(6);
        claim(0, d); chk("lvl_claim", d, 4);
        cpl(1, 4); settle(4);
        rd(12'h100, d); chk("cpl_wrong_tgt_pend", 64'(d[4]), 0);
        claim(0, d); chk("cpl_wrong_tgt_claim", d, 0);
        cpl(0, 4); settle(4);
        rd(12'h100, d); chk("lvl_repend", 64'(d[4]), 1);
        claim(0, d); chk("lvl_claim2", d, 4);
        cpl(0, 36); settle(4);
        rd(12'h100, d); chk("cpl_oor_pend", 64'(d[4]), 0);
        claim(0, d); chk("cpl_oor_claim", d, 0);

        // Claimed by one target is invisible to the other
        do_reset(); irq_sources_i = '0;
        set_prio(6, 2); set_en(0, 32'h40); set_en(1, 32'h40);
        irq_sources_i[6] = 1'b1; settle(6);
        chk("both_irq", 64'(irq_o), 3);
        claim(0, d); chk("shared_claim0", d, 6);
        settle(2);
        chk("shared_irq1_drop", 64'(irq_o[1]), 0);
        claim(1, d); chk("shared_claim1", d, 0);

        // Reset while source 6 is in flight leaves nothing in flight
        do_reset();
        set_prio(6, 2); set_en(0, 32'h40);
        settle(6);
        rd(12'h100, d); chk("rst_infl_pend", 64'(d[6]), 1);
        claim(0, d); chk("rst_infl_claim", d, 6);

`ifdef PLIC_MT_EDGE_TRIG_EN
        // Edge gateway: one latched edge, further edges dropped
        do_reset(); irq_sources_i = '0;
        wr(12'h180, 32'h200, 4'hf); set_prio(9, 1); set_en(0, 32'h200);
        pulse(9);
        rd(12'h100, d); chk("edge_pend", 64'(d[9]), 1);
        claim(0, d); chk("edge_claim", d, 9);
        pulse(9); pulse(9);
        rd(12'h100, d); chk("edge_latched", 64'(d[9]), 0);
        cpl(0, 9); settle(3);
        rd(12'h100, d); chk("edge_transfer", 64'(d[9]), 1);
        claim(0, d); chk("edge_claim2", d, 9);
        cpl(0, 9); settle(3);
        rd(12'h100, d); chk("edge_once", 64'(d[9]), 0);
        claim(0, d); chk("edge_claim3", d, 0);
        // Trigger change drops the latch
        pulse(9);
        claim(0, d); chk("edge_claim4", d, 9);
        pulse(9);
        wr(12'h180, 32'h0, 4'hf);
        cpl(0, 9); settle(4);
        rd(12'h100, d); chk("trig_chg_latch_clr", 64'(d[9]), 0);
`endif

        // Randomized level rounds against the model
        do_reset(); irq_sources_i = '0;
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 4; k++) set_prio($urandom_range(1, NS - 1), $urandom_range(0, PMAX));
            for (int t = 0; t < NT; t++) begin
                set_en(t, $urandom);
                set_thr(t, $urandom_range(0, PMAX - 1));
            end
            src = $urandom;
            irq_sources_i = src;
            settle(6);
            m_pend = m_pend | (src & ~m_infl & ~32'h1);
            rd(12'h100, d); chk("rnd_pend", d, m_pend);
            for (int t = 0; t < NT; t++) chk("rnd_irq", 64'(irq_o[t]), 64'(m_sel(t) != 0));
            for (int t = 0; t < NT; t++) begin
                id = m_sel(t);
                claim(t, d); chk("rnd_claim", d, 64'(id));
                if (id != 0) begin
                    m_pend[id] = 1'b0;
                    m_infl[id] = 1'b1;
                    who[id] = t;
                end
            end
            for (int i = 1; i < NS; i++) begin
                if (m_infl[i]) begin
                    cpl(who[i], 32'(i));
                    m_infl[i] = 1'b0;
                end
            end
            settle(5);
            m_pend = m_pend | (src & ~32'h1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/plic_mt.md
PLIC_MT -- requirements
Module: plic_mt

Interface
REQ-001 Parameter NUM_SOURCES, default 32: number of interrupt sources including reserved source 0; legal range 2..64.
REQ-002 Parameter NUM_TARGETS, default 2: number of interrupt targets (contexts); legal range 1..4.
REQ-003 Parameter PRIO_BITS, default 3: width of the priority and threshold fields; legal range 1..3.
REQ-004 clk_i  input  1  clock; all state updates on its rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 stb_i  input  1  register access strobe; one access per cycle.
REQ-007 adr_i  input  12  byte address within the block.
REQ-008 byte_sel_i  input  4  write byte enables.
REQ-009 we_i  input  1  1 = write, 0 = read.
REQ-010 dat_i  input  32  write data.
REQ-011 dat_o  output  32  combinational read data; 0 for unmapped addresses.
REQ-012 irq_sources_i  input  NUM_SOURCES  asynchronous interrupt source lines; bit 0 is ignored.
REQ-013 irq_o  output  NUM_TARGETS  registered per-target interrupt request.

Function
REQ-014 The register map SHALL be as follows:
- 0x000+4*i: priority of source i.
- 0x100 / 0x104: pending bits [31:0] / [63:32], read-only.
- 0x180 / 0x184: trigger type bits (1 = edge).
- 0x200+0x10*t (+4 for the upper word): enable bits of target t.
- 0x400+0x10*t: threshold of target t.
- 0x404+0x10*t: claim/complete of target t.
REQ-015 Bits for source IDs >= NUM_SOURCES and for targets >= NUM_TARGETS SHALL read 0 and ignore writes; source 0 priority, pending, enable and trigger bits SHALL be hardwired to 0.
REQ-016 Enable and trigger words SHALL honour byte_sel_i per byte; priority and threshold writes SHALL take effect only when byte_sel_i[0]=1 and SHALL keep dat_i[PRIO_BITS-1:0].
REQ-017 Each source SHALL pass through a 2-flop synchroniser before its gateway.
REQ-018 Level gateway: while the synchronised level is 1, the source is not in-flight and it is not pending, pending SHALL be set.
REQ-019 Edge gateway: a synchronised rising edge SHALL set pending if the source is not in-flight; otherwise it SHALL set a one-deep edge latch. The latch SHALL transfer into pending on the cycle after completion. Further edges while the latch is set SHALL be dropped.
REQ-020 Target t eligibility: a source is eligible for target t when pending & enable[t] & priority > 0 & priority > threshold[t] (strict comparison).
REQ-021 Target t selection: the eligible source with the highest priority is selected; ties SHALL go to the lowest ID.
REQ-022 irq_o[t] SHALL register (any eligible source for t) each cycle; from a source asserting, it rises on the 4th rising clk_i edge (2 synchroniser, 1 pending, 1 irq).
REQ-023 A claim read of target t SHALL return the selected ID, or 0 if none. When the ID is nonzero, the same edge SHALL clear pending and set in-flight for that source.
REQ-024 A complete write to target t of ID k SHALL clear in-flight for k only if 0 < k < NUM_SOURCES, k is in-flight and enable[t][k]=1; otherwise the write is ignored without error.
REQ-025 Simultaneous events: a claim and a pending set of the same source on the same edge SHALL resolve to claim winning (pending=0, in-flight=1); an edge arriving on the completing edge SHALL set pending directly.
REQ-026 A source claimed by one target SHALL no longer be eligible for any target until it is completed.
REQ-027 Changing the trigger type of an in-flight source SHALL clear its edge latch and leave in-flight unchanged.

Reset
REQ-028 On rst_ni low, all priority, enable, threshold, trigger, pending, in-flight, edge-latch and synchroniser flops SHALL clear asynchronously, and irq_o SHALL be 0.
REQ-029 A reset asserted mid-claim SHALL leave no source in-flight after release.

Configuration
REQ-030 Macro PLIC_MT_EDGE_TRIG_EN SHALL control edge-trigger support.
- Defined: the trigger registers and edge gateways (REQ-019) SHALL exist.
- Undefined: all sources SHALL be level-triggered, 0x180/0x184 SHALL read 0 and ignore writes, and no edge-latch flops SHALL be generated.

Verification
REQ-031 Target 0 enable=0x4, priority[2]=5, threshold[0]=0; irq_sources_i[2] rises -> irq_o[0]=1 on the 4th edge; claim read returns 2; pending[2]=0.
REQ-032 Sources 3 and 5 both priority 4 and enabled on target 1 -> claim returns 3; after complete(3) and a second claim -> returns 5.
REQ-033 Priority[7]=3, threshold[1]=3 -> irq_o[1] stays 0; threshold[1]=2 -> irq_o[1]=1 one cycle after the write edge.
REQ-034 Edge source 9 claimed, then two more rising edges -> pending[9]=0; complete(9) -> pending[9]=1 exactly once, and a second claim then returns 0 after completion.
REQ-035 Level source 4 held high: claim, then complete(4) -> pending[4] re-sets; complete(4) issued from a target with enable bit 4 = 0 is ignored (in-flight stays 1).
REQ-036 Source 6 enabled on both targets; target 0 claims 6 -> irq_o[1] drops and target 1 claim returns 0.
